adc_controller: RTL
===================

Name: adc_controller

Overview:
- Serial readout controller for the 8-channel simultaneous-sampling ADC (AD7608-class, serial mode, single DOUT line) that feeds the PID input path.
- On a start pulse it performs four steps: pulse CONVST, wait for BUSY to rise then fall, assert CS, and clock out N_CHAN x W_DATA bits MSB-first.
- Each completed word is presented as signed data with its channel number and a one-cycle valid pulse, which the cycle controller consumes.
- It is the acquisition-side counterpart of the DAC serial writer.

Parameters:
- W_DATA, 18, ADC word width (signed two's complement).
- W_CHS, 3, channel index width.
- N_CHAN, 8, channels read per conversion.
- SCLK_HALF, 4, clk_in cycles per SCLK half-period (must be >=3).
- T_CONVST, 2, clk_in cycles CONVST is held low.
- BUSY_TO, 1023, clk_in cycles allowed for BUSY to rise, and separately for BUSY to fall, before timeout.

Ports:
- clk_in, input, 1, system clock (50 MHz).
- reset_in, input, 1, synchronous, active-low reset.
- cstart_in, input, 1, one-cycle pulse: begin conversion and readout cycle.
- busy_in, input, 1, ADC BUSY pin (asynchronous).
- dout_in, input, 1, ADC serial data pin (asynchronous).
- nconvst_out, output, 1, conversion start to ADC, active low.
- ncs_out, output, 1, ADC chip select, active low.
- sclk_out, output, 1, ADC serial clock, idles high.
- data_out, output, W_DATA, last received word.
- channel_out, output, W_CHS, channel of data_out.
- data_valid_out, output, 1, one-cycle pulse per received word.
- cycle_done_out, output, 1, one-cycle pulse after the last channel.
- timeout_out, output, 1, one-cycle pulse on BUSY timeout.

Behaviour:
- Reset (reset_in==0 at a clk_in edge), from any state:
  - state -> ST_IDLE; all counters cleared.
  - nconvst_out=1, ncs_out=1, sclk_out=1.
  - data_out=0, channel_out=0, all pulses 0.
  - Reset mid-readout aborts silently: no valid or done pulse.
- Synchronizers: busy_in and dout_in each pass through 2 flops before use; all logic uses the synchronized versions.
- State machine:
  - ST_IDLE: on cstart_in go to ST_CONVST. cstart_in is ignored in every other state.
  - ST_CONVST: nconvst_out=0 for exactly T_CONVST cycles, then go to ST_BUSY_HI.
  - ST_BUSY_HI: wait for synchronized busy==1, then go to ST_BUSY_LO. If BUSY_TO cycles elapse first, go to ST_IDLE and pulse timeout_out.
  - ST_BUSY_LO: wait for busy==0, then go to ST_CS_SETUP. Timeout rule is the same as ST_BUSY_HI.
  - ST_CS_SETUP: ncs_out=0, sclk_out=1, hold SCLK_HALF cycles, then go to ST_READ.
  - ST_READ: ncs_out=0.
    - sclk_out toggles every SCLK_HALF cycles, starting with a falling edge.
    - The synchronized dout is shifted in (MSB first) on the cycle sclk_out is driven low->high.
    - After W_DATA rising edges: data_out <= shift register, channel_out <= channel counter, data_valid_out=1 for one cycle, channel counter +1.
    - After channel N_CHAN-1 completes, go to ST_DONE with sclk_out left high.
  - ST_DONE: ncs_out=1, cycle_done_out=1 for one cycle, then go to ST_IDLE.
- data_out and channel_out hold their value until the next valid word.
- Channel counter wraps to 0 at the start of each cycle. Bit counter resets per word. SCLK stays continuous across word boundaries (no gap).
- Latency: cstart_in to first data_valid_out = 1 + T_CONVST + BUSY duration + 2 (sync) + SCLK_HALF + 2*SCLK_HALF*W_DATA cycles (±1 for the sync edge). Consecutive valids are 2*SCLK_HALF*W_DATA cycles apart.
- If busy is already high in ST_IDLE it is ignored; a conversion requires the rise after CONVST.

Decomposition:
- Shared package holds:
  - State encodings (ST_IDLE..ST_DONE, 3 bits).
  - Default widths W_DATA/W_CHS/N_CHAN, also used by dac_controller.
  - ADC timing constants T_CONVST, BUSY_TO.
- One natural sub-module: adc_sclk_gen, a counter-based divider. It provides sclk_out plus rise and fall strobes, enabled only in ST_READ, and idles high.

Test Plan:
- Reset held low with cstart_in=1 -> ncs_out=1, nconvst_out=1, sclk_out=1, data_out=0, no pulses.
- cstart_in, BUSY model high 40 cycles, 8 words 0x1FFFF, 0x20000, 0x00001, 0x3FFFF, 0x0AAAA, 0x15555, 0x00000, 0x12345 -> 8 data_valid_out pulses with matching data_out, channel_out 0..7, valid spacing 144 cycles, then one cycle_done_out.
- BUSY never rises -> timeout_out after 1023 cycles in ST_BUSY_HI, return to ST_IDLE, no valid, ncs_out stays 1.
- Second cstart_in during readout -> ignored; exactly 8 valids, one done.
- reset_in low while channel 3 is mid-word -> immediate idle outputs, no further valids; the next cstart_in produces a clean 8-word cycle starting at channel 0.
- Check SCLK timing against the ADC model: sclk_out idles high, half-period 4 cycles, ncs_out falls ≥4 cycles before the first SCLK edge, and exactly 144 rising edges occur per cycle.

Source files
------------

// File: rtl/adc_controller_pkg.sv
// rtl/adc_controller_pkg.sv - shared widths, ADC timing constants and FSM encodings
package adc_controller_pkg;

  // Data path widths shared with the DAC serial writer
  localparam int ADC_W_DATA = 18;
  localparam int ADC_W_CHS  = 3;
  localparam int ADC_N_CHAN = 8;

  // ADC interface timing, in clk_in cycles
  localparam int ADC_SCLK_HALF = 4;
  localparam int ADC_T_CONVST  = 2;
  localparam int ADC_BUSY_TO   = 1023;

  // Readout state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CONVST   = 3'd1;
  localparam logic [2:0] ST_BUSY_HI  = 3'd2;
  localparam logic [2:0] ST_BUSY_LO  = 3'd3;
  localparam logic [2:0] ST_CS_SETUP = 3'd4;
  localparam logic [2:0] ST_READ     = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  // Bits needed to hold 0..max_count, never less than one
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

  // Largest of three timing constants, used to size the shared phase timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// rtl/adc_sclk_gen.sv - counter-based SCLK divider with rise/fall strobes, idles high
module adc_sclk_gen
  import adc_controller_pkg::*;
#(
  parameter int SCLK_HALF = ADC_SCLK_HALF
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic enable,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int HC_W = cnt_width(SCLK_HALF - 1);

  logic [HC_W-1:0] half_cnt;
  logic            half_end;

  // Strobes mark the cycle whose clock edge drives sclk to its new level
  assign half_end = (half_cnt == HC_W'(SCLK_HALF - 1));
  assign rise     = enable && half_end && !sclk;
  assign fall     = enable && half_end && sclk;

  // Half-period counter; sclk parks high and the phase restarts whenever disabled
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      half_cnt <= '0;
      sclk     <= 1'b1;
    end else if (!enable) begin
      half_cnt <= '0;
      sclk     <= 1'b1;
    end else if (half_end) begin
      half_cnt <= '0;
      sclk     <= ~sclk;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_controller.sv
// rtl/adc_controller.sv - AD7608-class serial readout: CONVST, BUSY handshake, 8-word shift-in
module adc_controller
  import adc_controller_pkg::*;
#(
  parameter int W_DATA    = ADC_W_DATA,
  parameter int W_CHS     = ADC_W_CHS,
  parameter int N_CHAN    = ADC_N_CHAN,
  parameter int SCLK_HALF = ADC_SCLK_HALF,
  parameter int T_CONVST  = ADC_T_CONVST,
  parameter int BUSY_TO   = ADC_BUSY_TO
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     cstart_in,
  input  logic                     busy_in,
  input  logic                     dout_in,
  output logic                     nconvst_out,
  output logic                     ncs_out,
  output logic                     sclk_out,
  output logic signed [W_DATA-1:0] data_out,
  output logic [W_CHS-1:0]         channel_out,
  output logic                     data_valid_out,
  output logic                     cycle_done_out,
  output logic                     timeout_out
);

  localparam int TMR_W = cnt_width(max3(T_CONVST, BUSY_TO, SCLK_HALF) - 1);
  localparam int BIT_W = cnt_width(W_DATA - 1);

  logic [2:0]        state;
  logic [TMR_W-1:0]  tmr;
  logic [BIT_W-1:0]  bit_cnt;
  logic [W_CHS-1:0]  chan;
  logic [W_DATA-1:0] shift;

  logic [1:0] busy_s;
  logic [1:0] dout_s;
  logic       busy_q;
  logic       busy_sync;
  logic       dout_sync;
  logic       busy_rise;

  logic sclk_en;
  logic sclk_rise;
  logic sclk_fall_unused;

  assign busy_sync = busy_s[1];
  assign dout_sync = dout_s[1];
  // A conversion is recognised only by a fresh BUSY rise, so a stuck-high pin never qualifies
  assign busy_rise = busy_sync && !busy_q;
  assign sclk_en   = (state == ST_READ);

  // Two-flop synchronizers for the asynchronous ADC pins, plus a delayed BUSY for edge detect
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      busy_s <= '0;
      dout_s <= '0;
      busy_q <= 1'b0;
    end else begin
      busy_s <= {busy_s[0], busy_in};
      dout_s <= {dout_s[0], dout_in};
      busy_q <= busy_sync;
    end
  end

  adc_sclk_gen #(
    .SCLK_HALF(SCLK_HALF)
  ) u_sclk_gen (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .enable  (sclk_en),
    .sclk    (sclk_out),
    .rise    (sclk_rise),
    .fall    (sclk_fall_unused)
  );

  // Readout sequencer; pin levels and pulses are registered so the ADC sees glitch-free strobes
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state          <= ST_IDLE;
      tmr            <= '0;
      bit_cnt        <= '0;
      chan           <= '0;
      shift          <= '0;
      nconvst_out    <= 1'b1;
      ncs_out        <= 1'b1;
      data_out       <= '0;
      channel_out    <= '0;
      data_valid_out <= 1'b0;
      cycle_done_out <= 1'b0;
      timeout_out    <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      cycle_done_out <= 1'b0;
      timeout_out    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cstart_in) begin
            state       <= ST_CONVST;
            tmr         <= '0;
            bit_cnt     <= '0;
            chan        <= '0;
            nconvst_out <= 1'b0;
          end
        end

        ST_CONVST: begin
          if (tmr == TMR_W'(T_CONVST - 1)) begin
            state       <= ST_BUSY_HI;
            tmr         <= '0;
            nconvst_out <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        ST_BUSY_HI: begin
          if (busy_rise) begin
            state <= ST_BUSY_LO;
            tmr   <= '0;
          end else if (tmr == TMR_W'(BUSY_TO - 1)) begin
            state       <= ST_IDLE;
            tmr         <= '0;
            timeout_out <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        ST_BUSY_LO: begin
          if (!busy_sync) begin
            state   <= ST_CS_SETUP;
            tmr     <= '0;
            ncs_out <= 1'b0;
          end else if (tmr == TMR_W'(BUSY_TO - 1)) begin
            state       <= ST_IDLE;
            tmr         <= '0;
            timeout_out <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        ST_CS_SETUP: begin
          if (tmr == TMR_W'(SCLK_HALF - 1)) begin
            state <= ST_READ;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        ST_READ: begin
          // Sample on the cycle SCLK is driven high; the ADC updated DOUT on the preceding fall
          if (sclk_rise) begin
            shift <= {shift[W_DATA-2:0], dout_sync};
            if (bit_cnt == BIT_W'(W_DATA - 1)) begin
              bit_cnt        <= '0;
              data_out       <= $signed({shift[W_DATA-2:0], dout_sync});
              channel_out    <= chan;
              data_valid_out <= 1'b1;
              chan           <= chan + 1'b1;
              if (chan == W_CHS'(N_CHAN - 1)) begin
                state   <= ST_DONE;
                ncs_out <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_DONE: begin
          cycle_done_out <= 1'b1;
          state          <= ST_IDLE;
        end

        default: begin
          state       <= ST_IDLE;
          nconvst_out <= 1'b1;
          ncs_out     <= 1'b1;
        end
      endcase
    end
  end

endmodule
